ysyx_23060201_sram: RTL and testbench
=====================================

YSYX_23060201_SRAM -- requirements
Module: ysyx_23060201_sram

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of storage words (32-bit each).
REQ-002 SHALL have parameter LATENCY, default 2, meaning wait cycles between request accept and response, 0..15.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 1, initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1, responder can accept a request.
REQ-007 SHALL have port req_wen, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have port req_addr, input, 32, byte address.
REQ-009 SHALL have port req_wdata, input, 32, write data.
REQ-010 SHALL have port req_wmask, input, 4, byte-lane write enables, bit i for bits 8i+7:8i.
REQ-011 SHALL have port rsp_valid, output, 1, response present.
REQ-012 SHALL have port rsp_ready, input, 1, initiator accepts the response.
REQ-013 SHALL have port rsp_rdata, output, 32, read data; 0 for writes and errors.
REQ-014 SHALL have port rsp_err, output, 1, request was misaligned or out of range.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; one request outstanding at most.
REQ-016 SHALL assert req_ready only in IDLE; a request is accepted when req_valid and req_ready are both high at a clock edge.
REQ-017 SHALL register req_wen, req_addr, req_wdata and req_wmask on accept; later input changes SHALL have no effect on that transaction.
REQ-018 On accept, SHALL go to WAIT with the counter loaded to the effective latency, or straight to RESP if the effective latency is 0.
REQ-019 In WAIT, SHALL decrement the counter each cycle and enter RESP on the edge where the counter equals 1.
REQ-020 SHALL raise rsp_valid exactly L+1 cycles after the accept edge, where L is the effective latency.
REQ-021 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until the rsp_ready edge, then return to IDLE; req_ready SHALL NOT be high in the same cycle as rsp_valid.
REQ-022 Word index SHALL be addr[DEPTH_LOG2+1:2]; error SHALL be set if addr[1:0] != 0 or addr[31:DEPTH_LOG2+2] != 0.
REQ-023 Writes without error SHALL update only the masked byte lanes on the WAIT/IDLE-to-RESP edge; a mask of 4'b0000 SHALL write nothing and complete without error.
REQ-024 Reads SHALL sample storage on the edge entering RESP, returning any write completed earlier.
REQ-025 Erroneous requests SHALL not modify storage and SHALL respond with rsp_err=1 and rsp_rdata=0 after the normal latency.

Reset
REQ-026 When rst is low, SHALL asynchronously force state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready SHALL be 1 once rst is high.
REQ-027 Reset mid-transaction SHALL abandon the transaction; a pending write that has not reached RESP SHALL not be performed.
REQ-028 Storage contents SHALL not be reset.

Configuration
REQ-029 With YSYX_23060201_SRAM_RAND_DELAY_EN defined, SHALL include an 8-bit LFSR (x^8+x^6+x^5+x^4+1), reset to 8'hA5 and advancing every cycle; effective latency = LATENCY + lfsr[2:0], sampled at accept.
REQ-030 Without YSYX_23060201_SRAM_RAND_DELAY_EN, effective latency SHALL be LATENCY and no LFSR logic SHALL exist.

Verification
REQ-031 Write then read, LATENCY=2: write addr 0x10, data 0xDEADBEEF, mask 4'hF -> rsp_valid 3 cycles after accept, err 0; read 0x10 -> rdata 0xDEADBEEF.
REQ-032 Partial write: first store 0x11223344 at 0x20, then write 0xAABBCCDD with mask 4'b0101 -> a read of 0x20 returns 0x11BB33DD.
REQ-033 Errors: read 0x22 and read 0x400 (DEPTH_LOG2=8) -> rsp_err=1, rdata=0; a write to 0x401 leaves all words unchanged.
REQ-034 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable and req_ready=0 throughout; IDLE reached the cycle after rsp_ready=1.
REQ-035 LATENCY=0 and reset: read accepted -> rsp_valid the next cycle; pull rst low during WAIT of a write to 0x30 -> outputs 0 immediately and 0x30 is unchanged.
REQ-036 With the macro defined: 16 back-to-back reads -> every response delay lies in LATENCY+1..LATENCY+8 cycles and matches the LFSR reference model.

Source files
------------

// File: rtl/ysyx_23060201_sram.sv
// Single-port 32-bit SRAM behind a valid/ready request/response handshake with a programmable response latency.
// Define YSYX_23060201_SRAM_RAND_DELAY_EN to add an LFSR-driven random extra delay of 0..7 cycles.
module ysyx_23060201_sram #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      eff_lat;
  logic                  wen_q;
  logic [31:0]           addr_q, wdata_q;
  logic [3:0]            wmask_q;
  logic                  accept, enter_resp;
  logic                  t_wen, t_err;
  logic [31:0]           t_addr, t_wdata;
  logic [3:0]            t_wmask;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           mem [0:(1 << DEPTH_LOG2) - 1];

`ifdef YSYX_23060201_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr_q;

  // Fibonacci form of x^8+x^6+x^5+x^4+1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= 8'hA5;
    else      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign eff_lat = CNT_W'(LATENCY) + CNT_W'(lfsr_q[2:0]);
`else
  assign eff_lat = CNT_W'(LATENCY);
`endif

  assign req_ready = (state_q == IDLE) && rst;
  assign accept    = req_valid && req_ready;

  // A zero-latency request completes on its accept edge, before the request registers are loaded
  always_comb begin
    t_wen   = wen_q;
    t_addr  = addr_q;
    t_wdata = wdata_q;
    t_wmask = wmask_q;
    if (state_q == IDLE) begin
      t_wen   = req_wen;
      t_addr  = req_addr;
      t_wdata = req_wdata;
      t_wmask = req_wmask;
    end
  end

  assign t_err = (t_addr[1:0] != 2'b00) || (t_addr[31:DEPTH_LOG2+2] != '0);
  assign idx   = t_addr[DEPTH_LOG2+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (eff_lat == '0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = eff_lat;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign enter_resp = (state_q != RESP) && (state_d == RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (accept) begin
      wen_q   <= req_wen;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wmask_q <= req_wmask;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (enter_resp) begin
      rsp_valid <= 1'b1;
      rsp_err   <= t_err;
      rsp_rdata <= (t_err || t_wen) ? '0 : mem[idx];
    end else if ((state_q == RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

  // Storage is not reset; an abandoned transaction never reaches enter_resp
  always_ff @(posedge clk) begin
    if (enter_resp && t_wen && !t_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (t_wmask[b]) mem[idx][8*b +: 8] <= t_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060201_sram.sv
// Directed self-checking bench for ysyx_23060201_sram: one instance with LATENCY=2, one with LATENCY=0.
module tb_ysyx_23060201_sram;

  localparam int unsigned LAT_A = 2;
  localparam int unsigned LAT_B = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_wen   = 1'b0;
  logic [31:0] req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wmask = '0;
  logic        rsp_ready = 1'b1;
  logic        sel       = 1'b0;

  logic        va, vb;
  logic        rr_a, rr_b, rv_a, rv_b, re_a, re_b;
  logic [31:0] rd_a, rd_b;
  logic        req_ready_m, rsp_valid_m, rsp_err_m;
  logic [31:0] rsp_rdata_m;

  assign va          = req_valid && !sel;
  assign vb          = req_valid && sel;
  assign req_ready_m = sel ? rr_b : rr_a;
  assign rsp_valid_m = sel ? rv_b : rv_a;
  assign rsp_err_m   = sel ? re_b : re_a;
  assign rsp_rdata_m = sel ? rd_b : rd_a;

  ysyx_23060201_sram #(.DEPTH_LOG2(8), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(va), .req_ready(rr_a), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rv_a), .rsp_ready(rsp_ready), .rsp_rdata(rd_a), .rsp_err(re_a)
  );

  ysyx_23060201_sram #(.DEPTH_LOG2(8), .LATENCY(LAT_B)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(vb), .req_ready(rr_b), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rv_b), .rsp_ready(rsp_ready), .rsp_rdata(rd_b), .rsp_err(re_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference LFSR, x^8+x^6+x^5+x^4+1 seeded with 8'hA5
  logic [7:0] m_lfsr;
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= 8'hA5;
    else      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int exp_delay(input int unsigned lat);
`ifdef YSYX_23060201_SRAM_RAND_DELAY_EN
    return int'(lat) + int'(m_lfsr[2:0]) + 1;
`else
    return int'(lat) + 1;
`endif
  endfunction

  task automatic wait_rsp(output int dly);
    dly = 1;
    while (!rsp_valid_m && dly < 40) begin
      @(posedge clk); #1;
      dly++;
    end
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the response is consumed.
  task automatic xfer(input logic s, input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] mask, output logic [31:0] rdata, output logic err,
                      output int dly, output int edly);
    int n;
    sel = s; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = mask;
    rsp_ready = 1'b1; req_valid = 1'b1;
    n = 0;
    while (!req_ready_m && n < 32) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_ready_before_accept", req_ready_m, 1);
    edly = exp_delay(s ? LAT_B : LAT_A);
    @(posedge clk); #1;
    req_valid = 1'b0; req_wen = ~wen; req_addr = 32'hFFFF_FFFF; req_wdata = ~wdata; req_wmask = ~mask;
    wait_rsp(dly);
    rdata = rsp_rdata_m;
    err   = rsp_err_m;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          d, ed;

  initial begin
    #2;
    check("reset_rsp_valid", rv_a, 0);
    check("reset_rsp_rdata", rd_a, 32'h0);
    check("reset_rsp_err", re_a, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", rr_a, 1);

    xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, d, ed);
    check("wr10_delay", d, ed);
    check("wr10_err", er, 0);
    check("wr10_rdata", rd, 32'h0);
    xfer(0, 0, 32'h10, 32'h0, 4'h0, rd, er, d, ed);
    check("rd10_delay", d, ed);
    check("rd10_rdata", rd, 32'hDEADBEEF);

    xfer(0, 1, 32'h20, 32'h11223344, 4'hF, rd, er, d, ed);
    xfer(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, d, ed);
    xfer(0, 0, 32'h20, 32'h0, 4'h0, rd, er, d, ed);
    check("partial_rdata", rd, 32'h11BB33DD);

    xfer(0, 1, 32'h10, 32'h0, 4'h0, rd, er, d, ed);
    check("mask0_err", er, 0);
    xfer(0, 0, 32'h10, 32'h0, 4'h0, rd, er, d, ed);
    check("mask0_unchanged", rd, 32'hDEADBEEF);

    xfer(0, 1, 32'h0, 32'h01234567, 4'hF, rd, er, d, ed);
    xfer(0, 0, 32'h22, 32'h0, 4'h0, rd, er, d, ed);
    check("rd22_err", er, 1);
    check("rd22_rdata", rd, 32'h0);
    check("rd22_delay", d, ed);
    xfer(0, 0, 32'h400, 32'h0, 4'h0, rd, er, d, ed);
    check("rd400_err", er, 1);
    check("rd400_rdata", rd, 32'h0);
    xfer(0, 1, 32'h401, 32'hBADBAD00, 4'hF, rd, er, d, ed);
    check("wr401_err", er, 1);
    xfer(0, 1, 32'h410, 32'hBADBAD11, 4'hF, rd, er, d, ed);
    check("wr410_err", er, 1);
    xfer(0, 0, 32'h0, 32'h0, 4'h0, rd, er, d, ed);
    check("after_bad_w0", rd, 32'h01234567);
    xfer(0, 0, 32'h10, 32'h0, 4'h0, rd, er, d, ed);
    check("after_bad_w4", rd, 32'hDEADBEEF);

    // Backpressure: response held while rsp_ready is low
    sel = 0; req_wen = 0; req_addr = 32'h10; req_wmask = 4'h0; rsp_ready = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(d);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", rv_a, 1);
      check("bp_rdata", rd_a, 32'hDEADBEEF);
      check("bp_ready_low", rr_a, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", rv_a, 0);
    check("bp_release_ready", rr_a, 1);

    // Zero-latency instance
    xfer(1, 1, 32'h30, 32'hCAFEF00D, 4'hF, rd, er, d, ed);
    check("l0_wr_delay", d, ed);
    xfer(1, 0, 32'h30, 32'h0, 4'h0, rd, er, d, ed);
    check("l0_rd_delay", d, ed);
    check("l0_rd_rdata", rd, 32'hCAFEF00D);

    // Reset in WAIT abandons the write
    xfer(0, 1, 32'h30, 32'h55AA55AA, 4'hF, rd, er, d, ed);
    sel = 0; req_wen = 1; req_addr = 32'h30; req_wdata = 32'hFFFFFFFF; req_wmask = 4'hF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_wait_valid", rv_a, 0);
    check("rst_wait_err", re_a, 0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rst_wait_ready", rr_a, 1);
    xfer(0, 0, 32'h30, 32'h0, 4'h0, rd, er, d, ed);
    check("rst_wait_unchanged", rd, 32'h55AA55AA);

    // Reset in RESP clears outputs without a clock edge
    req_wen = 0; req_addr = 32'h30; rsp_ready = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(d);
    check("pre_rst_valid", rv_a, 1);
    #1 rst = 1'b0;
    #1;
    check("rst_resp_valid", rv_a, 0);
    check("rst_resp_rdata", rd_a, 32'h0);
    @(negedge clk); rst = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("rst_resp_ready", rr_a, 1);

`ifdef YSYX_23060201_SRAM_RAND_DELAY_EN
    for (int i = 0; i < 16; i++) begin
      xfer(0, 0, 32'h10, 32'h0, 4'h0, rd, er, d, ed);
      check("rand_delay", d, ed);
      check("rand_range", (d >= int'(LAT_A) + 1) && (d <= int'(LAT_A) + 8), 1);
      check("rand_rdata", rd, 32'hDEADBEEF);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
